// File: rtl/cc_matrix_row_serializer.sv
// cc_matrix_row_serializer
//   Serializes composed LED rows to a MAX7219-style 8x8 matrix driver.
//   After reset it sends five configuration words. Each Start then refreshes
//   every row, fetching one row at a time through RowSel.
//   Word layout: {4'h0, addr[3:0], data}. Words are shifted MSB first.
//   Each word takes 1 + (2*WORDW+1)*CLKDIV cycles, which is 1+33*CLKDIV for
//   8-bit rows.
// Ports:
//   CLOCK_50        system clock (rising edge)
//   RESET_InHigh    synchronous active-high reset
//   Start_In        frame refresh request, sampled only in IDLE
//   RowData_InBus   row data for the row selected by RowSel_OutBus
//   RowSel_OutBus   row currently requested (0..ROWS-1)
//   Busy_Out        init or frame transmission in progress
//   FrameDone_Out   1-cycle pulse in the first IDLE cycle after a frame
//   SerDin_Out / SerClk_Out / SerLoad_Out   serial DIN / CLK / LOAD
module cc_matrix_row_serializer #(
  parameter int         DATAWIDTH = 8,
  parameter int         ROWS      = 8,
  parameter int         CLKDIV    = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic                 CC_MATRIX_ROW_SERIALIZER_CLOCK_50,
  input  logic                 CC_MATRIX_ROW_SERIALIZER_RESET_InHigh,
  input  logic                 CC_MATRIX_ROW_SERIALIZER_Start_In,
  input  logic [DATAWIDTH-1:0] CC_MATRIX_ROW_SERIALIZER_RowData_InBus,
  output logic [2:0]           CC_MATRIX_ROW_SERIALIZER_RowSel_OutBus,
  output logic                 CC_MATRIX_ROW_SERIALIZER_Busy_Out,
  output logic                 CC_MATRIX_ROW_SERIALIZER_FrameDone_Out,
  output logic                 CC_MATRIX_ROW_SERIALIZER_SerDin_Out,
  output logic                 CC_MATRIX_ROW_SERIALIZER_SerClk_Out,
  output logic                 CC_MATRIX_ROW_SERIALIZER_SerLoad_Out
);

  localparam int WORDW = 8 + DATAWIDTH;
  localparam int BITW  = $clog2(WORDW);
  localparam int DIVW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_SHIFT, S_LATCH
  } state_t;

  logic clk, rst;
  assign clk = CC_MATRIX_ROW_SERIALIZER_CLOCK_50;
  assign rst = CC_MATRIX_ROW_SERIALIZER_RESET_InHigh;

  state_t            state, state_nxt;
  logic [WORDW-1:0]  shreg;
  logic [DIVW-1:0]   div_cnt;
  logic [BITW-1:0]   bit_cnt;
  logic              sclk;          // serial clock phase while shifting
  logic [2:0]        row;
  logic [2:0]        init_idx;
  logic              init_active;   // the current word belongs to the init sequence
  logic              frame_done;

  logic div_last, bit_last, row_last, init_last;
  assign div_last  = (div_cnt == DIVW'(CLKDIV - 1));
  assign bit_last  = (bit_cnt == BITW'(WORDW - 1));
  assign row_last  = (row == 3'(ROWS - 1));
  assign init_last = (init_idx == 3'd4);

  function automatic logic [WORDW-1:0] init_word(input logic [2:0] idx);
    logic [3:0] addr;
    logic [7:0] val;
    case (idx)
      3'd0:    begin addr = 4'hF; val = 8'h00; end  // display test off
      3'd1:    begin addr = 4'hC; val = 8'h01; end  // normal operation
      3'd2:    begin addr = 4'hB; val = 8'h07; end  // scan all 8 digits
      3'd3:    begin addr = 4'h9; val = 8'h00; end  // no BCD decode
      default: begin addr = 4'hA; val = {4'h0, INTENSITY}; end
    endcase
    return {4'h0, addr, DATAWIDTH'(val)};
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  state_nxt = S_SHIFT;   // INIT doubles as the load cycle of an init word
      S_IDLE:  if (CC_MATRIX_ROW_SERIALIZER_Start_In) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (div_last && sclk && bit_last) state_nxt = S_LATCH;
      S_LATCH: begin
        if (div_last) begin
          if (init_active) state_nxt = init_last ? S_IDLE : S_INIT;
          else             state_nxt = row_last  ? S_IDLE : S_LOAD;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // datapath: shift register, bit/phase timing, row and init sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      init_active <= 1'b1;
      init_idx    <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
      shreg       <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      sclk        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_INIT: begin
          shreg   <= init_word(init_idx);
          div_cnt <= '0;
          bit_cnt <= '0;
          sclk    <= 1'b0;
        end
        S_IDLE: row <= '0;
        S_LOAD: begin
          // RowSel is already stable here, so the row data is captured as-is
          shreg   <= {4'h0, 4'(row) + 4'd1, CC_MATRIX_ROW_SERIALIZER_RowData_InBus};
          div_cnt <= '0;
          bit_cnt <= '0;
          sclk    <= 1'b0;
        end
        S_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // advance on the high-to-low edge so DIN only moves while CLK is low
            if (sclk) begin
              shreg   <= {shreg[WORDW-2:0], 1'b0};
              bit_cnt <= bit_cnt + BITW'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        S_LATCH: begin
          if (div_last) begin
            div_cnt <= '0;
            if (init_active) begin
              if (init_last) init_active <= 1'b0;
              else           init_idx    <= init_idx + 3'd1;
            end else if (row_last) begin
              row        <= '0;
              frame_done <= 1'b1;
            end else begin
              row <= row + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // outputs
  always_comb begin
    CC_MATRIX_ROW_SERIALIZER_SerDin_Out  = 1'b0;
    CC_MATRIX_ROW_SERIALIZER_SerClk_Out  = 1'b0;
    CC_MATRIX_ROW_SERIALIZER_SerLoad_Out = 1'b0;
    CC_MATRIX_ROW_SERIALIZER_Busy_Out    = 1'b1;
    case (state)
      S_SHIFT: begin
        CC_MATRIX_ROW_SERIALIZER_SerDin_Out = shreg[WORDW-1];
        CC_MATRIX_ROW_SERIALIZER_SerClk_Out = sclk;
      end
      S_LATCH: CC_MATRIX_ROW_SERIALIZER_SerLoad_Out = 1'b1;
      S_IDLE:  CC_MATRIX_ROW_SERIALIZER_Busy_Out    = 1'b0;
      default: ;
    endcase
    CC_MATRIX_ROW_SERIALIZER_RowSel_OutBus = row;
    CC_MATRIX_ROW_SERIALIZER_FrameDone_Out = frame_done;
  end

endmodule

// File: tb/tb_cc_matrix_row_serializer.sv
// Bench for cc_matrix_row_serializer: one instance with CLKDIV=4 and one with
// CLKDIV=1. A serial monitor decodes words on LOAD rise into per-instance
// queues. These queues are compared against word lists built from the frame rules.
module tb_cc_matrix_row_serializer;
  localparam int P4   = 133;  // 1 + 33*4
  localparam int P1   = 34;   // 1 + 33*1
  localparam int ROWS = 8;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int nvec = 0;
  int nerr = 0;

  logic       rst0 = 1'b1, rst1 = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic [7:0] rd0, rd1 = 8'h00;
  logic [2:0] rs0, rs1;
  logic       busy0, busy1, fd0, fd1, din0, din1, sc0, sc1, ld0, ld1;

  assign rd0 = 8'h01 << rs0;  // row model: one lit LED per row

  cc_matrix_row_serializer #(.CLKDIV(4)) u4 (
    .CC_MATRIX_ROW_SERIALIZER_CLOCK_50(clk),
    .CC_MATRIX_ROW_SERIALIZER_RESET_InHigh(rst0),
    .CC_MATRIX_ROW_SERIALIZER_Start_In(start0),
    .CC_MATRIX_ROW_SERIALIZER_RowData_InBus(rd0),
    .CC_MATRIX_ROW_SERIALIZER_RowSel_OutBus(rs0),
    .CC_MATRIX_ROW_SERIALIZER_Busy_Out(busy0),
    .CC_MATRIX_ROW_SERIALIZER_FrameDone_Out(fd0),
    .CC_MATRIX_ROW_SERIALIZER_SerDin_Out(din0),
    .CC_MATRIX_ROW_SERIALIZER_SerClk_Out(sc0),
    .CC_MATRIX_ROW_SERIALIZER_SerLoad_Out(ld0)
  );

  cc_matrix_row_serializer #(.CLKDIV(1)) u1 (
    .CC_MATRIX_ROW_SERIALIZER_CLOCK_50(clk),
    .CC_MATRIX_ROW_SERIALIZER_RESET_InHigh(rst1),
    .CC_MATRIX_ROW_SERIALIZER_Start_In(start1),
    .CC_MATRIX_ROW_SERIALIZER_RowData_InBus(rd1),
    .CC_MATRIX_ROW_SERIALIZER_RowSel_OutBus(rs1),
    .CC_MATRIX_ROW_SERIALIZER_Busy_Out(busy1),
    .CC_MATRIX_ROW_SERIALIZER_FrameDone_Out(fd1),
    .CC_MATRIX_ROW_SERIALIZER_SerDin_Out(din1),
    .CC_MATRIX_ROW_SERIALIZER_SerClk_Out(sc1),
    .CC_MATRIX_ROW_SERIALIZER_SerLoad_Out(ld1)
  );

  wire [1:0] din  = {din1, din0};
  wire [1:0] sclk = {sc1, sc0};
  wire [1:0] load = {ld1, ld0};
  wire [1:0] rstv = {rst1, rst0};
  wire [1:0] fdv  = {fd1, fd0};

  logic [15:0] wq0[$];
  logic [15:0] wq1[$];
  logic [15:0] acc[2];
  int          nb[2];
  int          fdcnt[2] = '{0, 0};
  logic [1:0]  psclk = 2'b00, pload = 2'b00, pdin = 2'b00;

  logic [15:0] initw[5] = '{16'h0F00, 16'h0C01, 16'h0B07, 16'h0900, 16'h0A08};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // serial monitor: sample DIN on CLK rise, capture the word on LOAD rise
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (psclk[i] && sclk[i]) chk("din_stable_while_clk_high", 32'(din[i]), 32'(pdin[i]));
      if (rstv[i]) begin
        acc[i] <= '0;
        nb[i]  <= 0;
      end else begin
        if (sclk[i] && !psclk[i]) begin
          acc[i] <= {acc[i][14:0], din[i]};
          nb[i]  <= nb[i] + 1;
        end
        if (load[i] && !pload[i]) begin
          chk("bits_per_word", nb[i], 16);
          if (i == 0) wq0.push_back(acc[i]);
          else        wq1.push_back(acc[i]);
          nb[i] <= 0;
        end
        if (fdv[i]) fdcnt[i] <= fdcnt[i] + 1;
      end
    end
    psclk <= sclk;
    pload <= load;
    pdin  <= din;
  end

  task automatic expect_word(input int i, input logic [15:0] w, input string tag);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (i == 0) begin
      if (wq0.size() > 0) got = {16'h0, wq0.pop_front()};
    end else begin
      if (wq1.size() > 0) got = {16'h0, wq1.pop_front()};
    end
    chk(tag, got, {16'h0, w});
  endtask

  task automatic wait_busy_low(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((i == 0) ? busy0 : busy1) && n < 5000);
  endtask

  task automatic wait_fd(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((i == 0) ? fd0 : fd1) && n < 5000);
  endtask

  initial begin
    int n, t0, t1, s, d, fc;
    logic [7:0] plan[ROWS];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_din", 32'(din0), 0);
    chk("rst_clk", 32'(sc0), 0);
    chk("rst_load", 32'(ld0), 0);
    chk("rst_rowsel", 32'(rs0), 0);
    chk("rst_framedone", 32'(fd0), 0);
    chk("rst_busy", 32'(busy0), 1);

    // init sequence, CLKDIV=4
    rst0 = 1'b0;
    rst1 = 1'b0;
    wait_busy_low(0, n);
    chk("init_len_div4", n, 5 * P4);
    for (int k = 0; k < 5; k++) expect_word(0, initw[k], "init_word_div4");
    chk("idle_rowsel", 32'(rs0), 0);

    // one frame with one lit LED per row
    @(negedge clk); start0 = 1'b1; t0 = ecnt;
    @(negedge clk); start0 = 1'b0;
    chk("busy_after_start", 32'(busy0), 1);
    wait_fd(0, n);
    chk("frame_latency_div4", ecnt - t0, ROWS * P4 + 1);
    chk("frame_rowsel_zero", 32'(rs0), 0);
    chk("frame_busy_low", 32'(busy0), 0);
    for (int k = 0; k < ROWS; k++) begin
      logic [7:0] v;
      v = 8'h01 << k;
      expect_word(0, {4'h0, 4'(k + 1), v}, "frame_word");
    end
    @(negedge clk);
    chk("framedone_one_cycle", 32'(fd0), 0);

    // Start pulsed randomly while busy: exactly one frame
    repeat (5) @(negedge clk);
    fc = fdcnt[0];
    start0 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start0 = busy0 ? 1'($urandom_range(0, 1)) : 1'b0;
    end while (!fd0 && n < 5000);
    start0 = 1'b0;
    repeat (200) @(negedge clk);
    chk("retrigger_framedone_count", fdcnt[0] - fc, 1);
    chk("retrigger_word_count", wq0.size(), ROWS);
    for (int k = 0; k < ROWS; k++) begin
      logic [7:0] v;
      v = 8'h01 << k;
      expect_word(0, {4'h0, 4'(k + 1), v}, "retrigger_word");
    end

    // Start held high: back-to-back frames
    @(negedge clk); start0 = 1'b1; t0 = ecnt;
    wait_fd(0, n);
    t1 = ecnt;
    chk("held_first_latency", t1 - t0, ROWS * P4 + 1);
    wait_fd(0, n);
    start0 = 1'b0;
    chk("held_frame_period", ecnt - t1, ROWS * P4 + 1);
    chk("held_word_count", wq0.size(), 2 * ROWS);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < ROWS; k++) begin
        logic [7:0] v;
        v = 8'h01 << k;
        expect_word(0, {4'h0, 4'(k + 1), v}, "held_word");
      end
    @(negedge clk);
    chk("held_stop_idle", 32'(busy0), 0);

    // reset during bit 7 of row 3
    fc = fdcnt[0];
    @(negedge clk); start0 = 1'b1; s = ecnt + 1;
    @(negedge clk); start0 = 1'b0;
    while (ecnt < s + 3 * P4 + 1 + 7 * 8 + 3) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    chk("midrst_din", 32'(din0), 0);
    chk("midrst_clk", 32'(sc0), 0);
    chk("midrst_load", 32'(ld0), 0);
    chk("midrst_rowsel", 32'(rs0), 0);
    chk("midrst_busy", 32'(busy0), 1);
    chk("midrst_words_before", wq0.size(), 3);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] v;
      v = 8'h01 << k;
      expect_word(0, {4'h0, 4'(k + 1), v}, "midrst_word");
    end
    @(negedge clk);
    rst0 = 1'b0;
    wait_busy_low(0, n);
    chk("reinit_len", n, 5 * P4);
    chk("reinit_word_count", wq0.size(), 5);
    for (int k = 0; k < 5; k++) expect_word(0, initw[k], "reinit_word");
    chk("reinit_no_framedone", fdcnt[0] - fc, 0);

    // CLKDIV=1 instance: init words, then constant data frame
    chk("init_word_count_div1", wq1.size(), 5);
    for (int k = 0; k < 5; k++) expect_word(1, initw[k], "init_word_div1");
    rd1 = 8'hA5;
    @(negedge clk); start1 = 1'b1; t0 = ecnt;
    @(negedge clk); start1 = 1'b0;
    wait_fd(1, n);
    chk("frame_latency_div1", ecnt - t0, ROWS * P1 + 1);
    for (int k = 0; k < ROWS; k++) expect_word(1, {4'h0, 4'(k + 1), 8'hA5}, "a5_word");

    // row data toggles every cycle except the load cycle of each row
    for (int k = 0; k < ROWS; k++) plan[k] = 8'($urandom);
    @(negedge clk); start1 = 1'b1; s = ecnt + 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start1 = 1'b0;
      d = ecnt - s;
      if (d >= 0 && d % P1 == 0 && d / P1 < ROWS) rd1 = plan[d / P1];
      else                                          rd1 = 8'($urandom);
    end while (!fd1 && n < 5000);
    chk("toggle_word_count", wq1.size(), ROWS);
    for (int k = 0; k < ROWS; k++) expect_word(1, {4'h0, 4'(k + 1), plan[k]}, "toggle_word");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
